// File: rtl/melody_reader_if.sv
// Melody reader bus: playback controls, melody RAM read port and tone-generator outputs.
// Latency: none, wires only.
// Backpressure: none; the tone generator and the RAM always accept what the reader drives.
// Ports (master = reader side):
//   start/stop/loop  playback controls into the reader
//   RAddress/RamData melody RAM read address out, read data in
//   note_code/note_valid/beat_tick/busy/done  sequencer status out
interface melody_reader_if #(
  parameter int Width  = 8,
  parameter int AWidth = 6
);
  logic              start;
  logic              stop;
  logic              loop;
  logic [AWidth-1:0] RAddress;
  logic [Width-1:0]  RamData;
  logic [3:0]        note_code;
  logic              note_valid;
  logic              beat_tick;
  logic              busy;
  logic              done;

  modport master (
    input  start, stop, loop, RamData,
    output RAddress, note_code, note_valid, beat_tick, busy, done
  );

  modport slave (
    output start, stop, loop, RamData,
    input  RAddress, note_code, note_valid, beat_tick, busy, done
  );
endinterface

// File: rtl/melody_reader.sv
// Melody RAM read sequencer: fetches one note byte per step and holds it for its beats.
// Latency: start -> note_valid after 3 cycles (SyncRead=1) or 2 cycles (SyncRead=0).
// Backpressure: none; stop aborts immediately, start is ignored while busy.
// Ports: clock, reset (sync, active-high) plus bus (melody_reader_if.master):
//   start/stop/loop in, RAddress out / RamData in, note_code/note_valid/beat_tick/busy/done out.
module melody_reader #(
  parameter int Width      = 8,
  parameter int AWidth     = 6,
  parameter int Depth      = 64,
  parameter bit SyncRead   = 1'b1,
  parameter int BeatCycles = 12500000,
  parameter int GapCycles  = 2500000
) (
  input  logic                 clock,
  input  logic                 reset,
  melody_reader_if.master      bus
);

  // One counter serves both beat and gap timing, so size it for the longer of the two.
  localparam int CntMax = (BeatCycles > GapCycles) ? BeatCycles : GapCycles;
  localparam int CW     = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CW-1:0]     BeatLast = CW'(BeatCycles - 1);
  localparam logic [CW-1:0]     GapLast  = CW'((GapCycles > 0) ? GapCycles - 1 : 0);
  localparam logic [AWidth-1:0] LastPtr  = AWidth'(Depth - 1);

  typedef enum logic [2:0] {IDLE, FETCH, LATCH, PLAY, GAP, DONE} state_t;

  state_t            state, state_n;
  logic [AWidth-1:0] ptr, ptr_n;
  logic [AWidth-1:0] addr, addr_n;
  logic [3:0]        code, code_n;
  logic              valid, valid_n;
  logic [4:0]        beats, beats_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic              capture;
  logic              advance;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      addr  <= '0;
      code  <= '0;
      valid <= 1'b0;
      beats <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      addr  <= addr_n;
      code  <= code_n;
      valid <= valid_n;
      beats <= beats_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    addr_n  = addr;
    code_n  = code;
    valid_n = valid;
    beats_n = beats;
    cnt_n   = cnt;
    advance = 1'b0;
    // With a combinational RAM the byte is already valid during FETCH.
    capture = (state == LATCH) || ((state == FETCH) && !SyncRead);

    case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = FETCH;
          ptr_n   = '0;
          addr_n  = '0;
        end
      end
      FETCH: begin
        if (SyncRead) state_n = LATCH;
      end
      PLAY: begin
        if (cnt == BeatLast) begin
          cnt_n = '0;
          if (beats == 5'd1) begin
            // Silence as soon as the note ends, whether or not a gap follows.
            code_n  = '0;
            valid_n = 1'b0;
            if (GapCycles > 0) state_n = GAP;
            else               advance = 1'b1;
          end else begin
            beats_n = beats - 5'd1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      GAP: begin
        if (cnt == GapLast) begin
          cnt_n   = '0;
          advance = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
        ptr_n   = '0;
        addr_n  = '0;
      end
      default: state_n = IDLE;
    endcase

    if (capture) begin
      if (bus.RamData[7:0] == 8'hFF) begin
        state_n = DONE;
      end else begin
        code_n  = bus.RamData[7:4];
        valid_n = (bus.RamData[7:4] != 4'd0);
        beats_n = {1'b0, bus.RamData[3:0]} + 5'd1;
        cnt_n   = '0;
        state_n = PLAY;
      end
    end

    // loop only matters here, at the step advance decision.
    if (advance) begin
      if (ptr == LastPtr) begin
        if (bus.loop) begin
          ptr_n   = '0;
          addr_n  = '0;
          state_n = FETCH;
        end else begin
          state_n = DONE;
        end
      end else begin
        ptr_n   = ptr + AWidth'(1);
        addr_n  = ptr + AWidth'(1);
        state_n = FETCH;
      end
    end

    if (bus.stop) begin
      state_n = IDLE;
      ptr_n   = '0;
      addr_n  = '0;
      code_n  = '0;
      valid_n = 1'b0;
      beats_n = '0;
      cnt_n   = '0;
    end
  end

  assign bus.RAddress   = addr;
  assign bus.note_code  = code;
  assign bus.note_valid = valid;
  assign bus.beat_tick  = (state == PLAY) && (cnt == BeatLast);
  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);

endmodule

// File: tb/tb_melody_reader.sv
// Bench for melody_reader: one registered-RAM and one combinational-RAM instance.
// Latency: expected per-cycle output traces are built from the melody bytes.
// Backpressure: none; playback controls are driven directly.
module tb_melody_reader;
  localparam int BEAT  = 4;
  localparam int GAP   = 2;
  localparam int DEPTH = 64;

  typedef logic [13:0] vec_t;  // {RAddress, note_code, note_valid, beat_tick, busy, done}

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  melody_reader_if #(.Width(8), .AWidth(6)) bs ();
  melody_reader_if #(.Width(8), .AWidth(6)) bc ();

  melody_reader #(.Width(8), .AWidth(6), .Depth(DEPTH), .SyncRead(1'b1),
                  .BeatCycles(BEAT), .GapCycles(GAP)) dut_s (.clock(clock), .reset(reset), .bus(bs));
  melody_reader #(.Width(8), .AWidth(6), .Depth(DEPTH), .SyncRead(1'b0),
                  .BeatCycles(BEAT), .GapCycles(GAP)) dut_c (.clock(clock), .reset(reset), .bus(bc));

  logic [7:0] mem [DEPTH];
  always @(posedge clock) bs.RamData <= mem[bs.RAddress];
  assign bc.RamData = mem[bc.RAddress];

  int   n_vec = 0;
  int   n_err = 0;
  vec_t q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic vec_t obs_vec(input bit sel);
    if (sel) return {bs.RAddress, bs.note_code, bs.note_valid, bs.beat_tick, bs.busy, bs.done};
    return {bc.RAddress, bc.note_code, bc.note_valid, bc.beat_tick, bc.busy, bc.done};
  endfunction

  function automatic vec_t mk(input int a, input int c, input bit v, input bit t, input bit bz, input bit d);
    return {6'(a), 4'(c), v, t, bz, d};
  endfunction

  task automatic set_in(input bit sel, input logic st, input logic sp, input logic lp);
    if (sel) begin bs.start = st; bs.stop = sp; bs.loop = lp; end
    else     begin bc.start = st; bc.stop = sp; bc.loop = lp; end
  endtask

  // Reference: walk the melody bytes and lay out every cycle the playback should take.
  function automatic void build(input bit sync, input bit lp, input int limit);
    int ptr = 0;
    q.delete();
    while (q.size() < limit) begin
      logic [7:0] b;
      int note, beats;
      repeat (sync ? 2 : 1) q.push_back(mk(ptr, 0, 0, 0, 1, 0));
      b = mem[ptr];
      if (b == 8'hFF) begin
        q.push_back(mk(ptr, 0, 0, 0, 1, 1));
        q.push_back('0);
        break;
      end
      note  = int'(b[7:4]);
      beats = int'(b[3:0]) + 1;
      for (int i = 0; i < beats * BEAT; i++)
        q.push_back(mk(ptr, note, note != 0, (i % BEAT) == BEAT - 1, 1, 0));
      repeat (GAP) q.push_back(mk(ptr, 0, 0, 0, 1, 0));
      if (ptr == DEPTH - 1) begin
        if (!lp) begin
          q.push_back(mk(ptr, 0, 0, 0, 1, 1));
          q.push_back('0);
          break;
        end
        ptr = 0;
      end else begin
        ptr++;
      end
    end
  endfunction

  // Start playback, compare every cycle against the reference trace, and in loop mode
  // end with a stop. Also pulses start while busy, which must change nothing.
  task automatic play_check(input bit sel, input bit lp, input int limit,
                            output int nv, output int nt, output int nd);
    vec_t o;
    nv = 0; nt = 0; nd = 0;
    build(sel, lp, limit);
    @(negedge clock) set_in(sel, 1'b1, 1'b0, lp);
    @(negedge clock) set_in(sel, 1'b0, 1'b0, lp);
    for (int i = 0; i < q.size(); i++) begin
      if (i > 0) @(negedge clock);
      o = obs_vec(sel);
      chk($sformatf("trace%0d[%0d]", sel, i), 32'(o), 32'(q[i]));
      nv += int'(o[3]);
      nt += int'(o[2]);
      nd += int'(o[0]);
      if (i == 10 && q.size() > 12 && q[10][1]) set_in(sel, 1'b1, 1'b0, lp);
      if (i == 11) set_in(sel, 1'b0, 1'b0, lp);
    end
    if (lp) begin
      set_in(sel, 1'b0, 1'b1, lp);
      @(negedge clock) set_in(sel, 1'b0, 1'b0, 1'b0);
      chk("loop_stop_idle", 32'(obs_vec(sel)), 32'd0);
    end
  endtask

  task automatic latency(input bit sel, input int expect_cyc);
    int n;
    mem[0] = 8'h31; mem[1] = 8'hFF;
    @(negedge clock) set_in(sel, 1'b1, 1'b0, 1'b0);
    @(negedge clock) set_in(sel, 1'b0, 1'b0, 1'b0);
    n = 1;
    while (!obs_vec(sel)[3] && n < 10) begin
      @(negedge clock);
      n++;
    end
    chk($sformatf("latency%0d", sel), 32'(n), 32'(expect_cyc));
    set_in(sel, 1'b0, 1'b1, 1'b0);
    @(negedge clock) set_in(sel, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int nv, nt, nd, e;
    reset = 1'b1;
    set_in(1'b1, 1'b0, 1'b0, 1'b0);
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    foreach (mem[i]) mem[i] = 8'hFF;
    repeat (3) @(negedge clock);
    chk("reset_sync", 32'(obs_vec(1'b1)), 32'd0);
    chk("reset_comb", 32'(obs_vec(1'b0)), 32'd0);
    reset = 1'b0;

    // One two-beat note, then end marker.
    mem[0] = 8'h31; mem[1] = 8'hFF;
    play_check(1'b1, 1'b0, 100000, nv, nt, nd);
    chk("t1_valid_cycles", 32'(nv), 32'd8);
    chk("t1_ticks", 32'(nt), 32'd2);
    chk("t1_done", 32'(nd), 32'd1);

    // A three-beat rest.
    mem[0] = 8'h02;
    play_check(1'b1, 1'b0, 100000, nv, nt, nd);
    chk("t2_valid_cycles", 32'(nv), 32'd0);
    chk("t2_ticks", 32'(nt), 32'd3);
    chk("t2_done", 32'(nd), 32'd1);

    // Stop mid-beat, then replay from address 0.
    mem[0] = 8'h5F;
    @(negedge clock) set_in(1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clock) set_in(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (20) @(negedge clock);
    chk("t3_pre_stop_valid", 32'(obs_vec(1'b1)[3]), 32'd1);
    set_in(1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clock) set_in(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t3_stop_outputs", 32'(obs_vec(1'b1)), 32'd0);
    nd = 0;
    repeat (8) begin @(negedge clock); nd += int'(obs_vec(1'b1)[0]); end
    chk("t3_no_done", 32'(nd), 32'd0);
    play_check(1'b1, 1'b0, 100000, nv, nt, nd);
    chk("t3_replay_valid", 32'(nv), 32'd64);

    // Full 64-step melody, without and with loop.
    foreach (mem[i]) mem[i] = 8'h10;
    play_check(1'b1, 1'b0, 100000, nv, nt, nd);
    chk("t4_valid_cycles", 32'(nv), 32'd256);
    chk("t4_done", 32'(nd), 32'd1);
    play_check(1'b1, 1'b1, 600, nv, nt, nd);
    chk("t4_loop_no_done", 32'(nd), 32'd0);

    // Reset during FETCH, start+reset together, stop+start together.
    mem[0] = 8'h31; mem[1] = 8'hFF;
    @(negedge clock) set_in(1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clock) set_in(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t5_fetch_busy", 32'(obs_vec(1'b1)[1]), 32'd1);
    reset = 1'b1;
    @(negedge clock) reset = 1'b0;
    chk("t5_reset_fetch", 32'(obs_vec(1'b1)), 32'd0);
    set_in(1'b1, 1'b1, 1'b0, 1'b0); reset = 1'b1;
    @(negedge clock) begin set_in(1'b1, 1'b0, 1'b0, 1'b0); reset = 1'b0; end
    chk("t5_start_reset", 32'(obs_vec(1'b1)), 32'd0);
    set_in(1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clock) set_in(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t5_start_stop", 32'(obs_vec(1'b1)), 32'd0);
    @(negedge clock);
    chk("t5_stays_idle", 32'(obs_vec(1'b1)), 32'd0);

    // Start-to-note latency for both RAM styles.
    latency(1'b1, 3);
    latency(1'b0, 2);

    // Random melodies on both instances.
    for (int r = 0; r < 8; r++) begin
      foreach (mem[i]) mem[i] = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 3))};
      e = $urandom_range(1, 8);
      mem[e] = 8'hFF;
      play_check(r[0], 1'b0, 100000, nv, nt, nd);
      chk($sformatf("rand%0d_done", r), 32'(nd), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
